// File: rtl/if_stage_pc_regs.sv
// Fetch stage: program counter, IF/ID pipeline register and saturating
// stall/flush event counters for performance debug.
module if_stage_pc_regs #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          PC_INC    = 4,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 PCWrite,
    input  logic                 IF_ID_Write,
    input  logic                 IF_Flush,
    input  logic                 branch_or_jump_taken,
    input  logic [31:0]          branch_target,
    input  logic [31:0]          imem_instr,
    output logic [31:0]          imem_addr,
    output logic [31:0]          IF_ID_PC_plus4_out,
    output logic [31:0]          IF_ID_Instr_out,
    output logic                 IF_ID_Valid_out,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    localparam logic [31:0] PC_STEP = 32'(PC_INC);

    logic [31:0]          pc;
    logic [31:0]          pc_seq;
    logic [31:0]          pc_next;
    logic                 stall_event;
    logic                 stall_sat;
    logic                 flush_sat;

    // Sequential address wraps naturally modulo 2^32.
    assign pc_seq    = pc + PC_STEP;
    assign imem_addr = pc;

    // A redirect discards any wrong-path stall request.
    always_comb begin
        pc_next = pc;
        if (branch_or_jump_taken) begin
            pc_next = branch_target;
        end else if (PCWrite) begin
            pc_next = pc_seq;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // Flush wins over a held IF/ID so a bubble is inserted even mid-stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            IF_ID_PC_plus4_out <= 32'h0;
            IF_ID_Instr_out    <= 32'h0;
            IF_ID_Valid_out    <= 1'b0;
        end else if (IF_Flush) begin
            IF_ID_PC_plus4_out <= 32'h0;
            IF_ID_Instr_out    <= 32'h0;
            IF_ID_Valid_out    <= 1'b0;
        end else if (IF_ID_Write) begin
            IF_ID_PC_plus4_out <= pc_seq;
            IF_ID_Instr_out    <= imem_instr;
            IF_ID_Valid_out    <= 1'b1;
        end
    end

    assign stall_event = ~PCWrite & ~branch_or_jump_taken;
    assign stall_sat   = &stall_count;
    assign flush_sat   = &flush_count;

    // Event counters stick at all-ones and clear only on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_event && !stall_sat) begin
                stall_count <= stall_count + 1'b1;
            end
            if (IF_Flush && !flush_sat) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_stage_pc_regs.sv
// Directed vector bench for if_stage_pc_regs, built with 4-bit counters so
// saturation is reachable in a few cycles.
module tb_if_stage_pc_regs;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          PCWrite;
    logic          IF_ID_Write;
    logic          IF_Flush;
    logic          branch_or_jump_taken;
    logic [31:0]   branch_target;
    logic [31:0]   imem_instr;
    logic [31:0]   imem_addr;
    logic [31:0]   IF_ID_PC_plus4_out;
    logic [31:0]   IF_ID_Instr_out;
    logic          IF_ID_Valid_out;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    if_stage_pc_regs #(
        .RESET_PC (32'h0000_0000),
        .PC_INC   (4),
        .CNT_WIDTH(CW)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .PCWrite             (PCWrite),
        .IF_ID_Write         (IF_ID_Write),
        .IF_Flush            (IF_Flush),
        .branch_or_jump_taken(branch_or_jump_taken),
        .branch_target       (branch_target),
        .imem_instr          (imem_instr),
        .imem_addr           (imem_addr),
        .IF_ID_PC_plus4_out  (IF_ID_PC_plus4_out),
        .IF_ID_Instr_out     (IF_ID_Instr_out),
        .IF_ID_Valid_out     (IF_ID_Valid_out),
        .stall_count         (stall_count),
        .flush_count         (flush_count)
    );

    typedef struct packed {
        logic          rst;
        logic          pcw;
        logic          ifw;
        logic          fl;
        logic          tk;
        logic [31:0]   tgt;
        logic [31:0]   instr;
        logic [31:0]   e_pc;
        logic [31:0]   e_pc4;
        logic [31:0]   e_instr;
        logic          e_valid;
        logic [CW-1:0] e_stall;
        logic [CW-1:0] e_flush;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic pcw, input logic ifw, input logic fl,
                         input logic tk, input logic [31:0] tgt, input logic [31:0] instr);
        reset = rst; PCWrite = pcw; IF_ID_Write = ifw; IF_Flush = fl;
        branch_or_jump_taken = tk; branch_target = tgt; imem_instr = instr;
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_pc4,
                             input logic [31:0] e_instr, input logic e_valid,
                             input logic [CW-1:0] e_stall, input logic [CW-1:0] e_flush);
        check({tag, ".pc"},    imem_addr,          e_pc);
        check({tag, ".pc4"},   IF_ID_PC_plus4_out, e_pc4);
        check({tag, ".instr"}, IF_ID_Instr_out,    e_instr);
        check({tag, ".valid"}, 32'(IF_ID_Valid_out), 32'(e_valid));
        check({tag, ".stall"}, 32'(stall_count),   32'(e_stall));
        check({tag, ".flush"}, 32'(flush_count),   32'(e_flush));
    endtask

    initial begin
        //            rst pcw ifw fl tk target        instr          pc            pc4           instr         v  st fl
        vecs[0]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,        32'h2002_0005, 32'h0,        32'h0,        32'h0,        1'b0,4'd0,4'd0};
        vecs[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        32'h2002_0005, 32'h4,        32'h4,        32'h2002_0005,1'b1,4'd0,4'd0};
        vecs[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        32'h2002_0005, 32'h8,        32'h8,        32'h2002_0005,1'b1,4'd0,4'd0};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'hDEAD_BEEF, 32'h8,        32'h8,        32'h2002_0005,1'b1,4'd1,4'd0};
        vecs[4]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        32'h1111_1111, 32'hC,        32'hC,        32'h1111_1111,1'b1,4'd1,4'd0};
        vecs[5]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        32'h2222_2222, 32'h10,       32'h10,       32'h2222_2222,1'b1,4'd1,4'd0};
        vecs[6]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,32'h40,       32'hBAD0_0001, 32'h40,       32'h0,        32'h0,        1'b0,4'd1,4'd1};
        vecs[7]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        32'h3333_3333, 32'h44,       32'h44,       32'h3333_3333,1'b1,4'd1,4'd1};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,32'h100,      32'hBAD0_0002, 32'h100,      32'h0,        32'h0,        1'b0,4'd1,4'd2};
        vecs[9]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        32'h4444_4444, 32'h104,      32'h104,      32'h4444_4444,1'b1,4'd1,4'd2};
        vecs[10] = '{1'b0,1'b1,1'b1,1'b0,1'b1,32'h200,      32'h5555_5555, 32'h200,      32'h108,      32'h5555_5555,1'b1,4'd1,4'd2};
        vecs[11] = '{1'b0,1'b1,1'b1,1'b1,1'b0,32'h0,        32'hBAD0_0003, 32'h204,      32'h0,        32'h0,        1'b0,4'd1,4'd3};
        vecs[12] = '{1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h6666_6666, 32'h204,      32'h208,      32'h6666_6666,1'b1,4'd2,4'd3};
        vecs[13] = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        32'hBAD0_0004, 32'h208,      32'h208,      32'h6666_6666,1'b1,4'd2,4'd3};
        vecs[14] = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'hFFFF_FFFC,32'hBAD0_0005, 32'hFFFF_FFFC,32'h208,      32'h6666_6666,1'b1,4'd2,4'd3};
        vecs[15] = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        32'h7777_7777, 32'h0,        32'h0,        32'h7777_7777,1'b1,4'd2,4'd3};

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].pcw, vecs[i].ifw, vecs[i].fl, vecs[i].tk,
                  vecs[i].tgt, vecs[i].instr);
            @(posedge clk); #1;
            check_all($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_pc4, vecs[i].e_instr,
                      vecs[i].e_valid, vecs[i].e_stall, vecs[i].e_flush);
        end

        // Stall and flush held for 20 cycles: both counters must stick at 15.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h8888_8888);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            check($sformatf("sat%0d.stall", i), 32'(stall_count), (2 + i > 15) ? 32'd15 : 32'(2 + i));
            check($sformatf("sat%0d.flush", i), 32'(flush_count), (3 + i > 15) ? 32'd15 : 32'(3 + i));
        end
        check_all("sat_end", 32'h0, 32'h0, 32'h0, 1'b0, 4'd15, 4'd15);

        // Stall with IF/ID loading, then reset asserted mid-stall with redirect/flush pending.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h9999_9999);
        @(posedge clk); #1;
        check_all("pre_rst", 32'h0, 32'h4, 32'h9999_9999, 1'b1, 4'd15, 4'd15);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h500, 32'hAAAA_AAAA);
        @(posedge clk); #1;
        check_all("mid_rst", 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 4'd0);

        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'hBBBB_BBBB);
        @(posedge clk); #1;
        check_all("post_rst", 32'h4, 32'h4, 32'hBBBB_BBBB, 1'b1, 4'd0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_stage_pc_regs.md
Name: if_stage_pc_regs

Overview:
- Fetch-side consumer of the hazard and flush controls: owns the program counter and the IF/ID pipeline register.
- Applies load-use stalls (PCWrite, IF_ID_Write) and taken branch/jump redirects with flushes (branch_or_jump_taken, IF_Flush).
- Sits between instruction memory and the ID stage.
- Also keeps saturating stall and flush event counters for performance debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_INC, 4, byte increment per sequential fetch.
- CNT_WIDTH, 16, width of each event counter.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- PCWrite  input  1  1 = PC may advance; 0 = hold PC (stall).
- IF_ID_Write  input  1  1 = IF/ID may load; 0 = hold IF/ID (stall).
- IF_Flush  input  1  1 = load a bubble into IF/ID.
- branch_or_jump_taken  input  1  1 = redirect PC to branch_target.
- branch_target  input  32  redirect address from MEM stage.
- imem_instr  input  32  instruction read combinationally at imem_addr.
- imem_addr  output  32  current PC, equal to the PC register.
- IF_ID_PC_plus4_out  output  32  registered PC + PC_INC of the fetched instruction.
- IF_ID_Instr_out  output  32  registered instruction; 32'h0 (nop) when bubble.
- IF_ID_Valid_out  output  1  1 = IF/ID holds a real instruction.
- stall_count  output  CNT_WIDTH  cycles with PCWrite=0 and no redirect.
- flush_count  output  CNT_WIDTH  cycles with IF_Flush=1.

Behaviour:
- Reset is sampled on the rising edge. It has priority over all other inputs, including mid-stall and mid-flush.
- Reset values: PC = RESET_PC, IF_ID_PC_plus4_out = 0, IF_ID_Instr_out = 0, IF_ID_Valid_out = 0, stall_count = 0, flush_count = 0.
- imem_addr = PC, combinational from the register. There is no output latency beyond the register.
- PC update, in priority order:
  - branch_or_jump_taken = 1: PC <= branch_target, regardless of PCWrite. Wrong-path stall is discarded.
  - else PCWrite = 1: PC <= PC + PC_INC, modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0.
  - else: PC holds.
- IF/ID update, in priority order:
  - IF_Flush = 1: Instr <= 0, PC_plus4 <= 0, Valid <= 0. Flush overrides IF_ID_Write = 0.
  - else IF_ID_Write = 1: Instr <= imem_instr, PC_plus4 <= PC + PC_INC, Valid <= 1.
  - else: hold all three fields.
- IF_Flush and branch_or_jump_taken are decoded independently. Normal operation asserts them together. Either one alone applies only its own rule above.
- Latency: an instruction presented at imem_addr in cycle N appears on the IF/ID outputs in cycle N+1, unless stalled or flushed in cycle N.
- Redirect: target fetched in cycle N+1; its IF/ID entry is valid in cycle N+2.
- stall_count increments by 1 in cycles with PCWrite = 0 and branch_or_jump_taken = 0. It saturates at all-ones with no wrap.
- flush_count increments by 1 in each cycle with IF_Flush = 1, and saturates the same way.
- Both counters clear only on reset.
- PCWrite = 0 with IF_ID_Write = 1, or the opposite combination, is legal. Each register obeys its own enable, with no cross-checking.
- No combinational path from any input to any output except imem_instr→nothing; all outputs are registered.

Test Plan:
- Reset then free run: release reset with imem_instr = 32'h2002_0005, all enables 1 → imem_addr 0, 4, 8. Cycle 1 IF/ID: Instr 32'h2002_0005, PC_plus4 4, Valid 1.
- Load-use stall: PCWrite = 0 and IF_ID_Write = 0 for 1 cycle at PC = 8 → PC stays 8, IF/ID unchanged, stall_count = 1. Next cycle PC = 12.
- Taken redirect: branch_or_jump_taken = 1, IF_Flush = 1, branch_target = 32'h40 at PC = 16 → next PC = 32'h40, Instr 0, Valid 0, flush_count = 1, stall_count unchanged.
- Flush during stall: PCWrite = 0, IF_ID_Write = 0, IF_Flush = 1, taken = 1, target = 32'h100 → PC = 32'h100, Valid 0, stall_count not incremented.
- Wrap and saturation: force PC to 32'hFFFF_FFFC via target, then advance → PC = 0. With CNT_WIDTH = 4, hold PCWrite = 0 for 20 cycles → stall_count = 15.
- Reset mid-operation: assert reset during a stall with a nonzero counter → next edge PC = RESET_PC, outputs 0, counters 0.
